msdap_out_deserializer: RTL and testbench
=========================================

// Module: msdap_out_deserializer
// PURPOSE
//  Downstream capture stage for the MSDAP serial outputs. Samples OutputL/OutputR
//  MSB-first on Sclk while OutReady is high and assembles 40-bit stereo result words.
//  Buffers completed words in a small FIFO and presents them on a valid/ready interface
//  to the host/checker side. Flags short (truncated) frames and FIFO overflow.
// PARAMETERS
//  WORD_W      40  bits per serial output word (per channel)
//  FIFO_DEPTH  4   completed-word FIFO entries (power of 2, >=2)
//  CNT_W       16  width of the mismatch counter (OUTDES_XOR_CHECK_EN only)
// PORTS
//  Sclk        in   1                        system clock; single clock domain, all logic on posedge
//  Reset       in   1                        synchronous, active-high reset
//  OutReady    in   1                        serial word strobe from MSDAP; high for WORD_W bits per word
//  OutputL     in   1                        left-channel serial data, MSB first
//  OutputR     in   1                        right-channel serial data, MSB first
//  Word_Ready  in   1                        consumer accepts the head word
//  Word_Valid  out  1                        FIFO non-empty
//  WordL       out  WORD_W                   left word at FIFO head
//  WordR       out  WORD_W                   right word at FIFO head
//  Fifo_Count  out  $clog2(FIFO_DEPTH+1)     stored word count
//  Overflow    out  1                        sticky: a completed word was dropped
//  Short_Err   out  1                        1-cycle pulse: OutReady fell mid-word
// BEHAVIOUR
//  - Reset: bit counter, shift regs, FIFO pointers cleared; all outputs 0 the cycle after Reset.
//  - States: IDLE (cnt==0), SHIFT (0<cnt<WORD_W). Each posedge with OutReady=1 shifts
//    {sreg,bit} on both channels and increments cnt; IDLE->SHIFT on first sampled bit.
//  - Completion: sample with cnt==WORD_W-1 completes word; cnt wraps to 0 and the word
//    is pushed the same edge; Word_Valid/WordL/WordR visible 1 cycle after last bit sampled.
//  - Back-to-back: OutReady held high across words -> next word starts on the very next
//    edge; no gap required, no bit lost.
//  - Short frame: OutReady=0 while in SHIFT -> Short_Err pulses 1 cycle, cnt cleared,
//    partial word discarded, -> IDLE. OutReady=0 in IDLE: no action.
//  - Pop: Word_Valid & Word_Ready on an edge removes head; next head appears next cycle.
//  - Full + push + pop same edge: both happen, count unchanged, no overflow.
//  - Full + push, no pop: new word dropped, FIFO unchanged, Overflow set until Reset.
//  - Empty + pop attempt: ignored (Word_Valid=0).
//  - Reset mid-word or with data queued: all state discarded; next OutReady rising starts fresh.
// CONFIGURATION
//  OUTDES_XOR_CHECK_EN defined: adds inputs RefL, RefR (1b, serial reference stream
//  sampled identically) and outputs Mismatch (1-cycle pulse) and Mismatch_Cnt[CNT_W-1:0].
//  On each word completion, if {refL,refR} != {wordL,wordR}: Mismatch pulses with the
//  push edge+1 and Mismatch_Cnt increments, saturating at all-ones; short frames never count.
//  Not defined: these ports and all compare logic are absent; core behaviour identical.
// STRUCTURE
//  msdap_pkg (shared): MSDAP_OUT_W=40 constant, typedef logic [39:0] msdap_out_word_t,
//  typedef struct {msdap_out_word_t l, r;} msdap_stereo_word_t.
//  Sub-module msdap_sync_fifo (WIDTH, DEPTH): single-clock FIFO, sync active-high reset,
//  push/pop/full/empty/count, simultaneous push+pop when full permitted.
//  Top holds counter, shift registers, state, error flags, optional compare.
// TESTING
//  1 Reset; shift L=40'h12_3456_789A, R=40'hFF_0000_00FF over 40 edges, Word_Ready=1
//    -> Word_Valid high exactly 1 cycle, 1 cycle after last bit, WordL/WordR match.
//  2 OutReady high 120 edges (3 words A,B,C), Word_Ready=0 -> Fifo_Count=3; then
//    Word_Ready=1 -> A,B,C drained in order, Fifo_Count 3->0.
//  3 5 words, Word_Ready=0, FIFO_DEPTH=4 -> Fifo_Count=4, Overflow=1, words 1-4 drain,
//    5th absent; Overflow stays 1 until Reset.
//  4 OutReady high 17 edges then low -> Short_Err one pulse, Fifo_Count=0; following
//    full word 40'hAA_AAAA_AAAA captured correctly.
//  5 Reset asserted at bit 20 -> all outputs 0 next cycle; next full word captured correctly.
//  6 (OUTDES_XOR_CHECK_EN) Ref==Output for word 1, Ref differs in LSB of word 2 ->
//    single Mismatch pulse on word 2, Mismatch_Cnt=1.

Source files
------------

// File: rtl/msdap_out_deserializer_pkg.sv
// Shared types and constants for the MSDAP output capture stage.
package msdap_out_deserializer_pkg;

    localparam int MSDAP_OUT_W = 40;

    typedef logic [MSDAP_OUT_W-1:0] msdap_out_word_t;

    typedef struct packed {
        msdap_out_word_t l;
        msdap_out_word_t r;
    } msdap_stereo_word_t;

    // Bit-assembly state: IDLE means no partial word is held.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } des_state_t;

endpackage

// File: rtl/msdap_out_deserializer_if.sv
// Valid/ready word bus between the deserializer (master) and its consumer (slave).
interface msdap_out_deserializer_if
    import msdap_out_deserializer_pkg::*;
#(
    parameter int WORD_W = MSDAP_OUT_W
);
    logic              Word_Valid;
    logic              Word_Ready;
    logic [WORD_W-1:0] WordL;
    logic [WORD_W-1:0] WordR;

    modport master (output Word_Valid, WordL, WordR, input  Word_Ready);
    modport slave  (input  Word_Valid, WordL, WordR, output Word_Ready);
endinterface

// File: rtl/msdap_out_deserializer_fifo.sv
// msdap_sync_fifo: single-clock FIFO with synchronous active-high reset.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module msdap_sync_fifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_wdata,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_rdata,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push, w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_count   = r_count;
    // Head is forced to zero when empty so the outputs never expose stale storage.
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Word storage.
    // NOTE: storage is deliberately not reset; pointers and count define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/msdap_out_deserializer.sv
// Captures the MSDAP serial outputs (MSB first while OutReady is high) into stereo
// words, queues them in a small FIFO and flags truncated frames and FIFO overflow.
// Optional feature macro: OUTDES_XOR_CHECK_EN adds a serial reference compare.
module msdap_out_deserializer
    import msdap_out_deserializer_pkg::*;
#(
    parameter int WORD_W     = MSDAP_OUT_W,
    parameter int FIFO_DEPTH = 4
`ifdef OUTDES_XOR_CHECK_EN
    , parameter int CNT_W    = 16
`endif
) (
    input  logic                              Sclk,
    input  logic                              Reset,
    input  logic                              OutReady,
    input  logic                              OutputL,
    input  logic                              OutputR,
`ifdef OUTDES_XOR_CHECK_EN
    input  logic                              RefL,
    input  logic                              RefR,
    output logic                              Mismatch,
    output logic [CNT_W-1:0]                  Mismatch_Cnt,
`endif
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   Fifo_Count,
    output logic                              Overflow,
    output logic                              Short_Err,
    msdap_out_deserializer_if.master          word_bus
);
    localparam int                BCNT_W   = $clog2(WORD_W);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WORD_W-1);

    des_state_t          r_state, w_state_next;
    logic [BCNT_W-1:0]   r_cnt;
    logic [WORD_W-2:0]   r_sreg_l, r_sreg_r;
    logic                r_short_err, r_overflow;
    logic                w_last, w_push, w_short, w_pop, w_drop;
    logic                w_empty, w_full;
    logic [WORD_W-1:0]   w_word_l, w_word_r;
    logic [2*WORD_W-1:0] w_head;

    assign w_last   = (r_cnt == LAST_BIT);
    assign w_word_l = {r_sreg_l, OutputL};
    assign w_word_r = {r_sreg_r, OutputR};
    assign w_pop    = !w_empty && word_bus.Word_Ready;
    assign w_drop   = w_push && w_full && !w_pop;

    // State register.
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge Sclk) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next state: enter SHIFT on the first bit, leave on word completion or OutReady drop.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (OutReady)            w_state_next = ST_SHIFT;
            ST_SHIFT: if (!OutReady || w_last) w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: push on the final bit, short-frame on OutReady low mid-word.
    always_comb begin
        w_push  = OutReady && w_last;
        w_short = (r_state == ST_SHIFT) && !OutReady;
    end

    // Bit counter and shift registers; an OutReady gap discards any partial word.
    always_ff @(posedge Sclk) begin
        if (Reset) begin
            r_cnt    <= '0;
            r_sreg_l <= '0;
            r_sreg_r <= '0;
        end else if (OutReady) begin
            r_sreg_l <= w_word_l[WORD_W-2:0];
            r_sreg_r <= w_word_r[WORD_W-2:0];
            r_cnt    <= w_last ? '0 : r_cnt + BCNT_W'(1);
        end else begin
            r_cnt    <= '0;
        end
    end

    // Error flags: one-cycle short-frame pulse and sticky overflow.
    always_ff @(posedge Sclk) begin
        if (Reset) begin
            r_short_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_short_err <= w_short;
            r_overflow  <= r_overflow | w_drop;
        end
    end

    msdap_sync_fifo #(
        .WIDTH (2*WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (Sclk),
        .i_rst   (Reset),
        .i_push  (w_push),
        .i_wdata ({w_word_l, w_word_r}),
        .i_pop   (word_bus.Word_Ready),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (Fifo_Count)
    );

    assign word_bus.Word_Valid = !w_empty;
    assign word_bus.WordL      = w_head[2*WORD_W-1:WORD_W];
    assign word_bus.WordR      = w_head[WORD_W-1:0];
    assign Short_Err           = r_short_err;
    assign Overflow            = r_overflow;

`ifdef OUTDES_XOR_CHECK_EN
    logic [WORD_W-2:0] r_ref_l, r_ref_r;
    logic              r_mismatch, w_diff;
    logic [CNT_W-1:0]  r_mis_cnt;

    assign w_diff = w_push && ({r_ref_l, RefL, r_ref_r, RefR} != {w_word_l, w_word_r});

    // Reference streams are shifted exactly like the data streams.
    always_ff @(posedge Sclk) begin
        if (Reset) begin
            r_ref_l <= '0;
            r_ref_r <= '0;
        end else if (OutReady) begin
            r_ref_l <= {r_ref_l[WORD_W-3:0], RefL};
            r_ref_r <= {r_ref_r[WORD_W-3:0], RefR};
        end
    end

    // Compare on each completed word; the counter saturates at all-ones.
    always_ff @(posedge Sclk) begin
        if (Reset) begin
            r_mismatch <= 1'b0;
            r_mis_cnt  <= '0;
        end else begin
            r_mismatch <= w_diff;
            if (w_diff && (r_mis_cnt != '1)) r_mis_cnt <= r_mis_cnt + CNT_W'(1);
        end
    end

    assign Mismatch     = r_mismatch;
    assign Mismatch_Cnt = r_mis_cnt;
`endif

endmodule

// File: tb/tb_msdap_out_deserializer.sv
// Bench for msdap_out_deserializer: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_msdap_out_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_ready, out_l, out_r;
    logic [2:0]  fifo_count;
    logic        overflow, short_err;
`ifdef OUTDES_XOR_CHECK_EN
    logic        ref_l, ref_r, mismatch;
    logic [15:0] mismatch_cnt;
`endif

    msdap_out_deserializer_if #(.WORD_W(40)) bus ();

    msdap_out_deserializer #(.WORD_W(40), .FIFO_DEPTH(4)) dut (
        .Sclk         (clk),
        .Reset        (rst),
        .OutReady     (out_ready),
        .OutputL      (out_l),
        .OutputR      (out_r),
`ifdef OUTDES_XOR_CHECK_EN
        .RefL         (ref_l),
        .RefR         (ref_r),
        .Mismatch     (mismatch),
        .Mismatch_Cnt (mismatch_cnt),
`endif
        .Fifo_Count   (fifo_count),
        .Overflow     (overflow),
        .Short_Err    (short_err),
        .word_bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [79:0] mq[$];          // expected FIFO contents, {L,R}
    int          m_nbits;
    logic [39:0] m_accl, m_accr;
    bit          m_over, m_short;
`ifdef OUTDES_XOR_CHECK_EN
    logic [39:0] m_refl, m_refr;
    bit          m_mis;
    int          m_mis_cnt;
`endif

    task automatic model_step();
        bit pop, done;
        if (rst) begin
            mq.delete();
            m_nbits = 0; m_over = 0; m_short = 0;
`ifdef OUTDES_XOR_CHECK_EN
            m_mis = 0; m_mis_cnt = 0;
`endif
            return;
        end
        pop     = (mq.size() != 0) && bus.Word_Ready;
        done    = 0;
        m_short = 0;
`ifdef OUTDES_XOR_CHECK_EN
        m_mis = 0;
`endif
        if (out_ready) begin
            if (m_nbits == 0) begin
                m_accl = 0; m_accr = 0;
`ifdef OUTDES_XOR_CHECK_EN
                m_refl = 0; m_refr = 0;
`endif
            end
            m_accl = m_accl * 2 + 40'(out_l);
            m_accr = m_accr * 2 + 40'(out_r);
`ifdef OUTDES_XOR_CHECK_EN
            m_refl = m_refl * 2 + 40'(ref_l);
            m_refr = m_refr * 2 + 40'(ref_r);
`endif
            m_nbits++;
            if (m_nbits == 40) begin
                done = 1; m_nbits = 0;
            end
        end else if (m_nbits != 0) begin
            m_short = 1; m_nbits = 0;
        end
        if (pop) void'(mq.pop_front());
        if (done) begin
            if (mq.size() < 4) mq.push_back({m_accl, m_accr});
            else               m_over = 1;
`ifdef OUTDES_XOR_CHECK_EN
            if ({m_refl, m_refr} != {m_accl, m_accr}) begin
                m_mis = 1;
                if (m_mis_cnt < 65535) m_mis_cnt++;
            end
`endif
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: outputs checked on the falling edge of every enabled cycle.
    initial forever begin
        logic [79:0] head;
        @(negedge clk);
        if (chk_en) begin
            head = (mq.size() != 0) ? mq[0] : 80'h0;
            check("cyc_valid", 80'(bus.Word_Valid), 80'(mq.size() != 0));
            check("cyc_wordL", 80'(bus.WordL), 80'(head[79:40]));
            check("cyc_wordR", 80'(bus.WordR), 80'(head[39:0]));
            check("cyc_count", 80'(fifo_count), 80'(mq.size()));
            check("cyc_overflow", 80'(overflow), 80'(m_over));
            check("cyc_short", 80'(short_err), 80'(m_short));
`ifdef OUTDES_XOR_CHECK_EN
            check("cyc_mismatch", 80'(mismatch), 80'(m_mis));
            check("cyc_mis_cnt", 80'(mismatch_cnt), 80'(m_mis_cnt));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drives the top n bits of each word MSB first, one per edge; returns #1 after the last edge.
    task automatic send_bits(input logic [39:0] l, input logic [39:0] r,
                             input logic [39:0] rl, input logic [39:0] rr, input int n);
        for (int i = 39; i > 39 - n; i--) begin
            out_ready = 1'b1;
            out_l     = l[i];
            out_r     = r[i];
`ifdef OUTDES_XOR_CHECK_EN
            ref_l     = rl[i];
            ref_r     = rr[i];
`else
            if (rl[i] !== rl[i] || rr[i] !== rr[i]) out_l = 1'bx;
`endif
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        out_ready = 1'b0; out_l = 1'b0; out_r = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    logic [39:0] wl [5];
    logic [39:0] wr [5];

    initial begin
        wl[0] = 40'h01_2345_6789; wr[0] = 40'hFE_DCBA_9876;
        wl[1] = 40'h80_0000_0001; wr[1] = 40'h7F_FFFF_FFFE;
        wl[2] = 40'h5A_5A5A_5A5A; wr[2] = 40'hA5_A5A5_A5A5;
        wl[3] = 40'hC3_0F00_F0C3; wr[3] = 40'h11_2233_4455;
        wl[4] = 40'hDE_ADBE_EF00; wr[4] = 40'h00_CAFE_BABE;

        rst = 1'b1; out_ready = 1'b0; out_l = 1'b0; out_r = 1'b0;
        bus.Word_Ready = 1'b0;
`ifdef OUTDES_XOR_CHECK_EN
        ref_l = 1'b0; ref_r = 1'b0;
`endif
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("rst_valid", 80'(bus.Word_Valid), 80'h0);
        check("rst_count", 80'(fifo_count), 80'h0);
        check("rst_overflow", 80'(overflow), 80'h0);
        check("rst_short", 80'(short_err), 80'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: single word, consumer always ready
        bus.Word_Ready = 1'b1;
        send_bits(40'h12_3456_789A, 40'hFF_0000_00FF, 40'h12_3456_789A, 40'hFF_0000_00FF, 40);
        out_ready = 1'b0;
        check("t1_valid", 80'(bus.Word_Valid), 80'h1);
        check("t1_wordL", 80'(bus.WordL), 80'h12_3456_789A);
        check("t1_wordR", 80'(bus.WordR), 80'hFF_0000_00FF);
        idle(1);
        check("t1_valid_one_cycle", 80'(bus.Word_Valid), 80'h0);

        // 2: three back-to-back words queued, then drained in order
        bus.Word_Ready = 1'b0;
        for (int k = 0; k < 3; k++) send_bits(wl[k], wr[k], wl[k], wr[k], 40);
        idle(1);
        check("t2_count3", 80'(fifo_count), 80'h3);
        bus.Word_Ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("t2_drainL", 80'(bus.WordL), 80'(wl[k]));
            check("t2_drainR", 80'(bus.WordR), 80'(wr[k]));
            check("t2_count", 80'(fifo_count), 80'(3 - k));
            @(posedge clk); #1;
        end
        check("t2_count0", 80'(fifo_count), 80'h0);

        // 3: five words into a four-entry FIFO
        bus.Word_Ready = 1'b0;
        for (int k = 0; k < 5; k++) send_bits(wl[k], wr[k], wl[k], wr[k], 40);
        idle(1);
        check("t3_count4", 80'(fifo_count), 80'h4);
        check("t3_overflow", 80'(overflow), 80'h1);
        bus.Word_Ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t3_drainL", 80'(bus.WordL), 80'(wl[k]));
            check("t3_drainR", 80'(bus.WordR), 80'(wr[k]));
            @(posedge clk); #1;
        end
        check("t3_empty", 80'(bus.Word_Valid), 80'h0);
        check("t3_overflow_sticky", 80'(overflow), 80'h1);

        // 4: truncated frame after 17 bits, then a full word
        bus.Word_Ready = 1'b0;
        send_bits(wl[4], wr[4], wl[4], wr[4], 17);
        idle(1);
        check("t4_short_pulse", 80'(short_err), 80'h1);
        check("t4_count0", 80'(fifo_count), 80'h0);
        idle(1);
        check("t4_short_gone", 80'(short_err), 80'h0);
        send_bits(40'hAA_AAAA_AAAA, 40'h55_5555_5555, 40'hAA_AAAA_AAAA, 40'h55_5555_5555, 40);
        out_ready = 1'b0;
        check("t4_wordL", 80'(bus.WordL), 80'hAA_AAAA_AAAA);
        check("t4_wordR", 80'(bus.WordR), 80'h55_5555_5555);
        check("t4_overflow_held", 80'(overflow), 80'h1);

        // 5: reset mid-word with data queued
        send_bits(wl[2], wr[2], wl[2], wr[2], 20);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_valid", 80'(bus.Word_Valid), 80'h0);
        check("t5_wordL", 80'(bus.WordL), 80'h0);
        check("t5_count", 80'(fifo_count), 80'h0);
        check("t5_overflow", 80'(overflow), 80'h0);
        check("t5_short", 80'(short_err), 80'h0);
        rst = 1'b0;
        send_bits(wl[3], wr[3], wl[3], wr[3], 40);
        out_ready = 1'b0;
        check("t5_wordL_after", 80'(bus.WordL), 80'(wl[3]));
        check("t5_wordR_after", 80'(bus.WordR), 80'(wr[3]));
        bus.Word_Ready = 1'b1;
        idle(2);

`ifdef OUTDES_XOR_CHECK_EN
        // 6: reference equal on word 1, LSB of right differs on word 2
        send_bits(wl[0], wr[0], wl[0], wr[0], 40);
        check("t6_no_mismatch", 80'(mismatch), 80'h0);
        send_bits(wl[1], wr[1], wl[1], wr[1] ^ 40'h1, 40);
        out_ready = 1'b0;
        check("t6_mismatch_pulse", 80'(mismatch), 80'h1);
        check("t6_mis_cnt", 80'(mismatch_cnt), 80'h1);
        idle(1);
        check("t6_pulse_gone", 80'(mismatch), 80'h0);
        check("t6_mis_cnt_held", 80'(mismatch_cnt), 80'h1);
`endif

        idle(3);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
